rca_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It splits a WIDTH-bit operation into STAGES equal chunks, with a registered carry between chunks, so one operation is accepted per cycle at a clock rate set by a CHUNK-bit ripple. It sits in the datapath library as the successor to the fixed 4-bit combinational ripple adder. It adds subtract mode, signed-overflow detection and valid/ready flow control.

---
 rtl/rca_pkg.sv | 17 +
 rtl/rca_pipe_if.sv | 36 +++
 rtl/rca_chunk.sv | 37 +++
 rtl/rca_pipe.sv | 136 +++++++++++++
 tb/tb_rca_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   RCA_ADD / RCA_SUB : encodings of the 'sub' mode input.
//   rca_width_ok()    : elaboration-time check that the operand width splits
//                       into equal, non-empty chunks, one per pipeline stage.
// ---------------------------------------------------------------------------
package rca_pkg;

    localparam logic RCA_ADD = 1'b0;
    localparam logic RCA_SUB = 1'b1;

    function automatic bit rca_width_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_pipe_if.sv
// ---------------------------------------------------------------------------
// rca_pipe_if
// Operand/result bus of rca_pipe, with valid/ready on both sides.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// Modports:
//   master : the producer/consumer around the adder (drives operands,
//            accepts results)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface rca_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/rca_chunk.sv
// ---------------------------------------------------------------------------
// rca_chunk
// Combinational N-bit ripple-carry adder slice.
//   a, b  : N-bit addends (b already inverted by the caller for subtract)
//   ci    : carry into bit 0
//   s     : N-bit sum
//   co    : carry out of bit N-1
//   c_msb : carry into bit N-1 (used for signed-overflow detection)
// ---------------------------------------------------------------------------
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [N:0] carry;

    // Bit-serial ripple: carry[i] is the carry into bit i.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = carry[N];
    assign c_msb = carry[N-1];

endmodule

// File: rtl/rca_pipe.sv
// ---------------------------------------------------------------------------
// rca_pipe
// Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is split
// into STAGES chunks of CHUNK bits; each stage ripples one chunk and hands
// its carry to the next stage through a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rca_pipe_if slave (operand in, result out, valid/ready each way)
// Level 0 registers the accepted operand (b pre-inverted and carry0 formed
// for subtract). Stage k reads level k and writes level k+1, so a result
// appears STAGES edges after acceptance. The whole pipe advances together
// whenever the output register is empty or being drained.
// ---------------------------------------------------------------------------
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    rca_pipe_if.slave bus
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!rca_width_ok(WIDTH, STAGES)) begin : g_width_check
        $error("rca_pipe: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    logic             adv;

    // v/c index = register level 0..STAGES; level STAGES is the output.
    logic [STAGES:0]  v_q, v_d;
    logic [STAGES:0]  c_q, c_d;

    // Operands entering stage k; the upper chunks travel along as the skew.
    logic [WIDTH-1:0] op_a_q [STAGES];
    logic [WIDTH-1:0] op_a_d [STAGES];
    logic [WIDTH-1:0] op_b_q [STAGES];
    logic [WIDTH-1:0] op_b_d [STAGES];

    // Partial result after stage k; lower chunks are carried forward.
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];

    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] s_w [STAGES];
    logic [STAGES-1:0] co_w;
    logic             c_msb_last;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == STAGES - 1) begin : g_last
            rca_chunk #(.N(CHUNK)) u_chunk (
                .a     (op_a_q[k][k*CHUNK +: CHUNK]),
                .b     (op_b_q[k][k*CHUNK +: CHUNK]),
                .ci    (c_q[k]),
                .s     (s_w[k]),
                .co    (co_w[k]),
                .c_msb (c_msb_last)
            );
        end else begin : g_mid
            // Only the top chunk's carry-into-MSB matters for overflow.
            logic c_msb_unused;
            rca_chunk #(.N(CHUNK)) u_chunk (
                .a     (op_a_q[k][k*CHUNK +: CHUNK]),
                .b     (op_b_q[k][k*CHUNK +: CHUNK]),
                .ci    (c_q[k]),
                .s     (s_w[k]),
                .co    (co_w[k]),
                .c_msb (c_msb_unused)
            );
        end
    end

    // Global enable: the output slot is free or is being taken this cycle.
    assign adv           = !v_q[STAGES] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[STAGES];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = c_q[STAGES];
    assign bus.ovf       = ovf_q;

    // Next values for every pipeline level; only loaded when adv is high,
    // so in_valid alone marks an accepted operand.
    always_comb begin
        v_d    = {v_q[STAGES-1:0], bus.in_valid};
        c_d    = '0;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        sum_d  = sum_q;

        // Subtract as a + ~b + ~cin: borrow-in becomes an inverted carry.
        c_d[0]          = (bus.sub == RCA_ADD) ? bus.cin : ~bus.cin;
        c_d[STAGES:1]   = co_w;
        op_a_d[0]       = bus.a;
        op_b_d[0]       = (bus.sub == RCA_SUB) ? ~bus.b : bus.b;

        for (int k = 1; k < STAGES; k++) begin
            op_a_d[k] = op_a_q[k-1];
            op_b_d[k] = op_b_q[k-1];
        end

        sum_d[0]            = '0;
        sum_d[0][CHUNK-1:0] = s_w[0];
        for (int k = 1; k < STAGES; k++) begin
            sum_d[k]                  = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK] = s_w[k];
        end

        ovf_d = c_msb_last ^ co_w[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                op_a_q[k] <= '0;
                op_b_q[k] <= '0;
                sum_q[k]  <= '0;
            end
        end else if (adv) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// ---------------------------------------------------------------------------
// tb_rca_pipe
// Self-checking bench for rca_pipe (WIDTH=16, STAGES=4). Results are
// compared against an integer-arithmetic reference of a +/- b +/- cin.
// ---------------------------------------------------------------------------
module tb_rca_pipe;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    rca_pipe_if #(.WIDTH(WIDTH)) bus ();

    rca_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        res_t              r;
        logic signed [15:0] as_v;
        logic signed [15:0] bs_v;
        int                ua, ub, ci, ur, sr;
        as_v = a;
        bs_v = b;
        ua   = int'(a);
        ub   = int'(b);
        ci   = cin ? 1 : 0;
        if (!sub) begin
            ur     = ua + ub + ci;
            sr     = int'(as_v) + int'(bs_v) + ci;
            r.cout = (ur > 65535);
        end else begin
            ur     = ua - ub - ci;
            sr     = int'(as_v) - int'(bs_v) - ci;
            r.cout = (ur >= 0);
        end
        r.sum = ur[15:0];
        r.ovf = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    // Presents one operand into an empty pipe and waits for its result.
    task automatic single_op(input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub,
                             output res_t got, output int lat);
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {bus.sum, bus.cout, bus.ovf};
    endtask

    task automatic test_reset();
        res_t got;
        int   lat;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
        end
        tests_run++;
        if ({bus.sum, bus.cout, bus.ovf} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h/%b/%b, expected 0000/0/0",
                     bus.sum, bus.cout, bus.ovf);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end

        // Put a nonzero result in the output register, then reset mid-clock.
        single_op(16'h1234, 16'h1111, 1'b0, 1'b0, got, lat);
        tests_run++;
        if (got !== {16'h2345, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_result: got %h, expected %h", got, {16'h2345, 2'b00});
        end
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_out_valid: got %b, expected 0", bus.out_valid);
        end
        tests_run++;
        if ({bus.sum, bus.cout, bus.ovf} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_outputs: got %h/%b/%b, expected 0000/0/0",
                     bus.sum, bus.cout, bus.ovf);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b, expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] es [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE};
        logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        res_t        got;
        int          lat;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            single_op(va[i], vb[i], vc[i], vs[i], got, lat);
            tests_run++;
            if (got !== {es[i], ec[i], eo[i]}) begin
                tests_failed++;
                $display("[TB] FAIL directed_%0d: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         i, got.sum, got.cout, got.ovf, es[i], ec[i], eo[i]);
            end
            tests_run++;
            if (lat !== STAGES) begin
                tests_failed++;
                $display("[TB] FAIL directed_latency_%0d: got %0d, expected %0d", i, lat, STAGES);
            end
        end
    endtask

    // Streams n_ops random operations; either a fixed 3-cycle stall
    // mid-stream or random out_ready / in_valid gaps.
    task automatic test_stream(input string name, input int n_ops, input bit random_flow);
        res_t        exp_q[$];
        res_t        expv;
        res_t        cur;
        res_t        prev_out     = '0;
        int          sent         = 0;
        int          got          = 0;
        int          cyc          = 0;
        int          stall_cycles = 0;
        bit          pending      = 1'b0;
        bit          stall;
        bit          prev_stall   = 1'b0;
        logic [15:0] pa = '0;
        logic [15:0] pb = '0;
        logic        pc = 1'b0;
        logic        ps = 1'b0;
        @(posedge clk);
        #1;
        while (got < n_ops && cyc < 200) begin
            if (!pending && sent < n_ops && (!random_flow || $urandom_range(0, 3) != 0)) begin
                pa      = 16'($urandom);
                pb      = 16'($urandom);
                pc      = 1'($urandom);
                ps      = 1'($urandom);
                pending = 1'b1;
            end
            bus.in_valid = pending;
            bus.a        = pa;
            bus.b        = pb;
            bus.cin      = pc;
            bus.sub      = ps;
            if (random_flow) bus.out_ready = ($urandom_range(0, 2) != 0);
            else             bus.out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            cur   = {bus.sum, bus.cout, bus.ovf};

            tests_run++;
            if (bus.in_ready !== !stall) begin
                tests_failed++;
                $display("[TB] FAIL %s_in_ready cyc %0d: got %b, expected %b",
                         name, cyc, bus.in_ready, !stall);
            end
            if (prev_stall) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || cur !== prev_out) begin
                    tests_failed++;
                    $display("[TB] FAIL %s_hold cyc %0d: got valid=%b %h, expected valid=1 %h",
                             name, cyc, bus.out_valid, cur, prev_out);
                end
            end
            if (stall) stall_cycles++;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s_extra cyc %0d: got result %h, expected none", name, cyc, cur);
                end else begin
                    expv = exp_q.pop_front();
                    if (cur !== expv) begin
                        tests_failed++;
                        $display("[TB] FAIL %s_result %0d: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 name, got, cur.sum, cur.cout, cur.ovf, expv.sum, expv.cout, expv.ovf);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                exp_q.push_back(ref_model(pa, pb, pc, ps));
                sent++;
                pending = 1'b0;
            end
            prev_stall = stall;
            prev_out   = cur;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests_run++;
        if (got !== n_ops) begin
            tests_failed++;
            $display("[TB] FAIL %s_count: got %0d results, expected %0d", name, got, n_ops);
        end
        if (!random_flow) begin
            tests_run++;
            if (stall_cycles !== 3) begin
                tests_failed++;
                $display("[TB] FAIL %s_stall_cycles: got %0d, expected 3", name, stall_cycles);
            end
        end
    endtask

    task automatic test_reset_midflight();
        res_t        got;
        res_t        expv;
        int          lat;
        logic [15:0] ra, rb;
        logic        rc, rs;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.cin      = 1'($urandom);
            bus.sub      = 1'($urandom);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midflight_ghost cyc %0d: got out_valid=%b, expected 0", i, bus.out_valid);
            end
        end
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rc   = 1'($urandom);
        rs   = 1'($urandom);
        expv = ref_model(ra, rb, rc, rs);
        single_op(ra, rb, rc, rs, got, lat);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL midflight_result: got %h, expected %h", got, expv);
        end
        tests_run++;
        if (lat !== STAGES) begin
            tests_failed++;
            $display("[TB] FAIL midflight_latency: got %0d, expected %0d", lat, STAGES);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        test_reset();
        test_directed();
        test_stream("back_to_back", 8, 1'b0);
        test_stream("random_flow", 40, 1'b1);
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
